// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and constants for the sequential divider.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seq_div_state_t;

  // Widest operand the divide-by-zero constant helper can produce.
  localparam int MAX_WIDTH = 128;

  // Quotient reported for a zero divisor: all ones in the low 'width' bits.
  function automatic logic [MAX_WIDTH-1:0] dbz_quotient(input int width);
    logic [MAX_WIDTH-1:0] ones;
    ones = '1;
    return ones >> (MAX_WIDTH - width);
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// seq_div_step: one combinational restoring radix-2 division iteration.
module seq_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;

  // Shift the next dividend bit in, try the subtraction, restore if it went negative.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {2'b00, divisor};
    if (!trial[WIDTH+1]) begin
      rem_out = trial[WIDTH:0];
      q_bit   = 1'b1;
    end else begin
      rem_out = shifted[WIDTH:0];
      q_bit   = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider with valid/ready handshakes.
// Signed operation is compiled in only when SEQ_DIV_SIGNED_EN is defined.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(dbz_quotient(WIDTH));
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  seq_div_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_mag, rem_mag;
  logic [WIDTH-1:0] quo_final, rem_final;
  logic             accept;
  logic             last_iter;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == LAST_CNT);

  seq_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  assign quo_mag = {dvd_q[WIDTH-2:0], q_bit};
  assign rem_mag = rem_next[WIDTH-1:0];

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg, dsr_neg;
  logic neg_quo, neg_rem;

  assign dvd_neg   = is_signed & dividend[WIDTH-1];
  assign dsr_neg   = is_signed & divisor[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -dividend : dividend;
  assign dsr_mag   = dsr_neg ? -divisor : divisor;
  assign quo_final = neg_quo ? -quo_mag : quo_mag;
  assign rem_final = neg_rem ? -rem_mag : rem_mag;

  // Capture the result sign corrections when an operand pair is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
    end else if (accept) begin
      neg_quo <= dvd_neg ^ dsr_neg;
      neg_rem <= dvd_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag   = dividend;
  assign dsr_mag   = divisor;
  assign quo_final = quo_mag;
  assign rem_final = rem_mag;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: zero divisor skips the iterations entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = (divisor == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_valid && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand capture, one quotient bit per BUSY cycle, result publish.
  // A zero divisor writes its result on accept and raises out_valid one edge later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      out_valid   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cnt   <= '0;
            rem_q <= '0;
            dvd_q <= dvd_mag;
            dsr_q <= dsr_mag;
            if (divisor == '0) begin
              quotient    <= DBZ_Q;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_next;
          dvd_q <= quo_mag;
          cnt   <= cnt + CNT_W'(1);
          if (last_iter) begin
            quotient  <= quo_final;
            remainder <= rem_final;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: self-checking bench for seq_div (WIDTH = 32) with a reference model.
`timescale 1ns/1ps
module tb_seq_div;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        is_signed = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  seq_div #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference model straight from the arithmetic rules.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; z = 1'b1;
    end else begin
      z = 1'b0;
      q = a / b;
      r = a % b;
`ifdef SEQ_DIV_SIGNED_EN
      if (s) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
`else
      sa = 0; sb = longint'(s);
`endif
    end
  endfunction

  // Present one operand pair, wait for accept, scramble inputs, wait for out_valid.
  task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output int waits, output int lat);
    logic ready_seen;
    waits = 0;
    dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
    forever begin
      ready_seen = in_ready;
      @(posedge clk);
      if (ready_seen || waits >= 200) break;
      #1 waits++;
    end
    #1;
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1 lat++;
    end
  endtask

  // Consume the current result with a one-cycle out_ready pulse.
  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    compared++;
    if ({out_valid, div_by_zero, busy, in_ready} !== 4'b0001 || quotient !== 0 || remainder !== 0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got ov=%b dbz=%b busy=%b ir=%b q=%h r=%h required 0 0 0 1 0 0",
               out_valid, div_by_zero, busy, in_ready, quotient, remainder);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL after_reset_idle: got ir=%b ov=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_unsigned();
    logic [31:0] av [3] = '{32'd100, 32'hFFFF_FFFF, 32'd5};
    logic [31:0] bv [3] = '{32'd7, 32'd1, 32'd9};
    logic [31:0] qv [3] = '{32'd14, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] rv [3] = '{32'd2, 32'd0, 32'd5};
    int waits, lat;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(av[i], bv[i], 1'b0, waits, lat);
      compared++;
      if (lat !== 32) begin
        mismatched++;
        $display("[TB] FAIL unsigned_latency[%0d]: got %0d required 32", i, lat);
      end
      compared++;
      if (quotient !== qv[i] || remainder !== rv[i] || div_by_zero !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL unsigned_result[%0d]: got q=%h r=%h z=%b required q=%h r=%h z=0",
                 i, quotient, remainder, div_by_zero, qv[i], rv[i]);
      end
      take_result();
    end
  endtask

  task automatic test_div_by_zero();
    int waits, lat;
    apply_stimulus(32'h1234, 32'd0, 1'b0, waits, lat);
    compared++;
    if (lat !== 1) begin
      mismatched++;
      $display("[TB] FAIL dbz_latency: got %0d required 1", lat);
    end
    compared++;
    if (quotient !== 32'hFFFF_FFFF || remainder !== 32'h1234 || div_by_zero !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL dbz_result: got q=%h r=%h z=%b required q=ffffffff r=00001234 z=1",
               quotient, remainder, div_by_zero);
    end
    take_result();
  endtask

  task automatic test_signed();
`ifdef SEQ_DIV_SIGNED_EN
    logic [31:0] av [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [31:0] bv [3] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] qv [3] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFD};
    logic [31:0] rv [3] = '{32'hFFFF_FFFF, 32'd0, 32'd1};
    logic        sv [3] = '{1'b1, 1'b1, 1'b1};
`else
    logic [31:0] av [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7};
    logic [31:0] bv [3] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] qv [3] = '{32'h7FFF_FFFC, 32'd0, 32'd0};
    logic [31:0] rv [3] = '{32'd1, 32'h8000_0000, 32'd7};
    logic        sv [3] = '{1'b1, 1'b1, 1'b1};
`endif
    int waits, lat;
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(av[i], bv[i], sv[i], waits, lat);
      compared++;
      if (quotient !== qv[i] || remainder !== rv[i] || lat !== 32) begin
        mismatched++;
        $display("[TB] FAIL signed_result[%0d]: got q=%h r=%h lat=%0d required q=%h r=%h lat=32",
                 i, quotient, remainder, lat, qv[i], rv[i]);
      end
      take_result();
    end
  endtask

  task automatic test_back_to_back();
    int waits, lat;
    logic [31:0] q1, r1;
    apply_stimulus(32'd12345, 32'd17, 1'b0, waits, lat);
    q1 = 32'd726; r1 = 32'd3;
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== q1 || remainder !== r1) begin
        mismatched++;
        $display("[TB] FAIL hold[%0d]: got ov=%b ir=%b q=%h r=%h required 1 0 %h %h",
                 c, out_valid, in_ready, quotient, remainder, q1, r1);
      end
      @(posedge clk); #1;
    end
    take_result();
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL release: got ir=%b ov=%b required 1 0", in_ready, out_valid);
    end
    apply_stimulus(32'd999, 32'd4, 1'b0, waits, lat);
    compared++;
    if (waits !== 0 || quotient !== 32'd249 || remainder !== 32'd3 || lat !== 32) begin
      mismatched++;
      $display("[TB] FAIL back_to_back: got waits=%0d q=%h r=%h lat=%0d required 0 000000f9 00000003 32",
               waits, quotient, remainder, lat);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int waits, lat;
    dividend = 32'hDEAD_BEEF; divisor = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    compared++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_busy: got busy=%b ov=%b required 1 0", busy, out_valid);
    end
    #2 rst = 1'b0;
    #1;
    compared++;
    if ({out_valid, div_by_zero, busy, in_ready} !== 4'b0001 || quotient !== 0 || remainder !== 0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_clear: got ov=%b dbz=%b busy=%b ir=%b q=%h r=%h required 0 0 0 1 0 0",
               out_valid, div_by_zero, busy, in_ready, quotient, remainder);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_no_result: got ov=%b busy=%b required 0 0", out_valid, busy);
    end
    apply_stimulus(32'd1000, 32'd10, 1'b0, waits, lat);
    compared++;
    if (quotient !== 32'd100 || remainder !== 32'd0 || lat !== 32) begin
      mismatched++;
      $display("[TB] FAIL post_reset_op: got q=%h r=%h lat=%0d required 00000064 00000000 32",
               quotient, remainder, lat);
    end
    take_result();
  endtask

  task automatic test_random();
    int waits, lat;
    logic [31:0] a, b, eq, er;
    logic s, ez;
    for (int i = 0; i < 24; i++) begin
      a = (i % 6 == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      s = 1'($urandom_range(0, 1));
      model(a, b, s, eq, er, ez);
      apply_stimulus(a, b, s, waits, lat);
      compared++;
      if (quotient !== eq || remainder !== er || div_by_zero !== ez || lat !== (ez ? 1 : 32)) begin
        mismatched++;
        $display("[TB] FAIL random[%0d] %h/%h s=%b: got q=%h r=%h z=%b lat=%0d required q=%h r=%h z=%b lat=%0d",
                 i, a, b, s, quotient, remainder, div_by_zero, lat, eq, er, ez, ez ? 1 : 32);
      end
      take_result();
    end
  endtask

  // Global time bound so the bench always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_unsigned();
    test_div_by_zero();
    test_signed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
